// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash READ engine.
package spi_flash_pkg;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD, DESEL} state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam int         ADDR_BITS = 24;
    localparam int         WORD_BITS = 32;

    // Bytes arrive b0 first; shifted MSB-first they land as {b0,b1,b2,b3}.
    function automatic logic [WORD_BITS-1:0] pack_le(input logic [WORD_BITS-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock divider: mode-0 spiclk plus strobes flagging the edge about to happen.
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic spiclk,
    output logic rise,
    output logic fall
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;

    // Strobes are high in the cycle whose closing edge toggles spiclk.
    assign tick = en && (cnt == CW'(CLK_DIV - 1));
    assign rise = tick && !spiclk;
    assign fall = tick && spiclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            spiclk <= 1'b0;
        end else if (!en) begin
            cnt    <= '0;
            spiclk <= 1'b0;
        end else if (tick) begin
            cnt    <= '0;
            spiclk <= ~spiclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_flash_reader.sv
// SPI master issuing READ (0x03) and streaming little-endian 32-bit words
// out through a single valid/ready output register.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_IDLE = 4
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [7:0]           req_len,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_BITS-1:0] rsp_data,
    output logic                 rsp_last,
    output logic                 busy,
    output logic                 csb,
    output logic                 spiclk,
    output logic                 io0,
    input  logic                 io1
);
    localparam int DW = $clog2(CS_IDLE) + 1;

    state_t                 state;
    logic [WORD_BITS-1:0]   tx_sr;
    logic [WORD_BITS-2:0]   rx_sr;
    logic [WORD_BITS-1:0]   rx_next;
    logic [4:0]             bit_cnt;
    logic [7:0]             len_q;
    logic [7:0]             word_idx;
    logic [DW-1:0]          desel_cnt;
    logic                   word_end;
    logic                   last_done;
    logic                   en;
    logic                   rise;
    logic                   fall;

    assign en        = (state == CMD) || (state == ADDR) || (state == DATA);
    assign req_ready = ap_rst && (state == IDLE);
    assign rx_next   = {rx_sr, io1};
    // MOSI is the top of the shift register; zeros shift in behind the address.
    assign io0       = tx_sr[WORD_BITS-1];

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
        .clk    (ap_clk),
        .rst_n  (ap_rst),
        .en     (en),
        .spiclk (spiclk),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge ap_clk or negedge ap_rst) begin
        if (!ap_rst) begin
            state     <= IDLE;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            len_q     <= '0;
            word_idx  <= '0;
            desel_cnt <= '0;
            word_end  <= 1'b0;
            last_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            csb       <= 1'b1;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_last  <= 1'b0;
            end
            case (state)
                IDLE: if (req_valid) begin
                    tx_sr     <= {CMD_READ, req_addr};
                    len_q     <= req_len;
                    bit_cnt   <= '0;
                    word_idx  <= '0;
                    word_end  <= 1'b0;
                    last_done <= 1'b0;
                    csb       <= 1'b0;
                    busy      <= 1'b1;
                    state     <= CMD;
                end
                CMD, ADDR: begin
                    if (rise) begin
                        if (state == CMD && bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            state   <= ADDR;
                        end else if (state == ADDR && bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    if (fall) tx_sr <= tx_sr << 1;
                end
                DATA: begin
                    if (rise) begin
                        rx_sr <= rx_next[WORD_BITS-2:0];
                        if (bit_cnt == 5'd31) begin
                            bit_cnt   <= '0;
                            rsp_data  <= pack_le(rx_next);
                            rsp_valid <= 1'b1;
                            rsp_last  <= (word_idx == len_q);
                            last_done <= (word_idx == len_q);
                            word_idx  <= word_idx + 8'd1;
                            word_end  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    // Word boundary decisions happen on the fall that would start the next word.
                    if (fall) begin
                        tx_sr    <= tx_sr << 1;
                        word_end <= 1'b0;
                        if (word_end && last_done) begin
                            csb       <= 1'b1;
                            desel_cnt <= '0;
                            state     <= DESEL;
                        end else if (word_end && rsp_valid && !rsp_ready) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: if (rsp_ready) state <= DATA;
                DESEL: begin
                    if (desel_cnt == DW'(CS_IDLE - 1)) begin
                        if (!rsp_valid || rsp_ready) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        desel_cnt <= desel_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural SPI flash responder, response scoreboard, scenario tasks.
module tb_spi_flash_reader;
    localparam int CLK_DIV = 2;
    localparam int CS_IDLE = 4;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [23:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic        rsp_ready = 1'b0;
    logic        io1 = 1'b0;
    logic        req_ready, rsp_valid, rsp_last, busy, csb, spiclk, io0;
    logic [31:0] rsp_data;

    spi_flash_reader #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy), .csb(csb),
        .spiclk(spiclk), .io0(io0), .io1(io1)
    );

    always #5 ap_clk = ~ap_clk;

    int n_pass = 0;
    int n_total = 0;

    // Flash contents: fixed bytes at 0..7, a hash everywhere else.
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        logic [7:0] t [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        if (a < 24'd8) return t[a[2:0]];
        return (a[7:0] * 8'd7) ^ a[15:8] ^ (a[23:16] + 8'h3c);
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] base, input int i);
        logic [23:0] a;
        a = base + 24'(4 * i);
        return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
    endfunction

    // Flash responder and bus monitor, sampling away from the active edge.
    int          fbit = 0, data_rises = 0, sel_bits = 0, csb_falls = 0;
    int          hi_run = 0, last_gap = 0, io0_bad = 0, k;
    logic [31:0] hdr = '0;
    logic [7:0]  b;
    logic        prev_sclk = 1'b0, prev_csb = 1'b1, prev_io0 = 1'b0;

    always @(negedge ap_clk) begin
        if (csb) begin
            if (!prev_csb) sel_bits = fbit;
            fbit = 0;
            hi_run++;
        end else begin
            if (prev_csb) begin
                csb_falls++;
                last_gap = hi_run;
                hi_run = 0;
            end
            if (spiclk && !prev_sclk) begin
                if (io0 !== prev_io0) io0_bad++;
                if (fbit < 32) hdr = {hdr[30:0], io0};
                else data_rises++;
                fbit++;
            end
            if (!spiclk && prev_sclk && fbit >= 32) begin
                k = fbit - 32;
                b = fbyte(hdr[23:0] + 24'(k / 8));
                io1 = b[7 - (k % 8)];
            end
        end
        prev_sclk = spiclk;
        prev_csb  = csb;
        prev_io0  = io0;
    end

    typedef struct {logic [31:0] d; logic l;} rsp_t;
    rsp_t q[$];

    always @(negedge ap_clk)
        if (rsp_valid && rsp_ready) q.push_back('{rsp_data, rsp_last});

    function automatic rsp_t qget(input int i);
        rsp_t r;
        r = '{32'hxxxxxxxx, 1'bx};
        if (i < q.size()) r = q[i];
        return r;
    endfunction

    // 0: always ready, 1: random, 2: stalled
    int rdy_mode = 0;
    always @(posedge ap_clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send_req(input logic [23:0] a, input logic [7:0] l);
        int t = 0;
        req_addr  = a;
        req_len   = l;
        req_valid = 1'b1;
        while (!req_ready && t < 5000) begin tick; t++; end
        n_total++;
        if (!req_ready) $display("FAIL req_accept timeout got req_ready=%b want 1", req_ready);
        else n_pass++;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (busy && t < budget) begin tick; t++; end
        n_total++;
        if (busy !== 1'b0) $display("FAIL done_timeout got busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset;
        ap_rst = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        n_total++;
        if ({csb, spiclk, io0, req_ready, rsp_valid, rsp_last, busy} !== 7'b1000000)
            $display("FAIL reset_outs got %b want 1000000", {csb, spiclk, io0, req_ready, rsp_valid, rsp_last, busy});
        else n_pass++;
        n_total++;
        if (rsp_data !== 32'h0) $display("FAIL reset_data got %h want 0", rsp_data);
        else n_pass++;
        ap_rst = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", req_ready);
        else n_pass++;
        tick;
    endtask

    task automatic test_basic;
        rdy_mode = 0;
        q.delete();
        data_rises = 0;
        csb_falls = 0;
        send_req(24'h0, 8'd1);
        wait_done(2000);
        n_total++;
        if (q.size() !== 2) $display("FAIL basic_count got %0d want 2", q.size());
        else n_pass++;
        n_total++;
        if ({qget(0).d, qget(0).l} !== {32'h44332211, 1'b0})
            $display("FAIL basic_w0 got %h/%b want 44332211/0", qget(0).d, qget(0).l);
        else n_pass++;
        n_total++;
        if ({qget(1).d, qget(1).l} !== {32'h88776655, 1'b1})
            $display("FAIL basic_w1 got %h/%b want 88776655/1", qget(1).d, qget(1).l);
        else n_pass++;
        n_total++;
        if (data_rises !== 64) $display("FAIL basic_rises got %0d want 64", data_rises);
        else n_pass++;
        n_total++;
        if ({csb_falls, sel_bits} !== {32'd1, 32'd96})
            $display("FAIL basic_csb got falls=%0d bits=%0d want 1/96", csb_falls, sel_bits);
        else n_pass++;
    endtask

    task automatic test_cmd_addr;
        rdy_mode = 1;
        q.delete();
        io0_bad = 0;
        send_req(24'h123456, 8'd0);
        wait_done(2000);
        n_total++;
        if (hdr !== 32'h03123456) $display("FAIL cmd_addr_bits got %h want 03123456", hdr);
        else n_pass++;
        n_total++;
        if (io0_bad !== 0) $display("FAIL io0_stable got %0d changes want 0", io0_bad);
        else n_pass++;
        n_total++;
        if ({q.size(), qget(0).d, qget(0).l} !== {32'd1, exp_word(24'h123456, 0), 1'b1})
            $display("FAIL cmd_addr_word got n=%0d %h/%b want 1 %h/1", q.size(), qget(0).d, qget(0).l, exp_word(24'h123456, 0));
        else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [23:0] a;
        int t = 0, bad = 0, r0;
        a = 24'($urandom);
        rdy_mode = 2;
        q.delete();
        send_req(a, 8'd3);
        while (!rsp_valid && t < 2000) begin tick; t++; end
        repeat (2 * CLK_DIV + 2) tick;
        r0 = data_rises;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (spiclk !== 1'b0 || csb !== 1'b0 || busy !== 1'b1) bad++;
        end
        n_total++;
        if (bad !== 0 || !rsp_valid) $display("FAIL hold_frozen got %0d bad cycles valid=%b want 0/1", bad, rsp_valid);
        else n_pass++;
        n_total++;
        if (data_rises !== r0) $display("FAIL hold_rises got %0d want %0d", data_rises, r0);
        else n_pass++;
        rdy_mode = 0;
        wait_done(3000);
        n_total++;
        if (q.size() !== 4) $display("FAIL hold_count got %0d want 4", q.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if ({qget(i).d, qget(i).l} !== {exp_word(a, i), i == 3})
                $display("FAIL hold_word%0d got %h/%b want %h/%b", i, qget(i).d, qget(i).l, exp_word(a, i), i == 3);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] a1, a2;
        int l1, l2, t = 0, bad = 0;
        a1 = 24'($urandom);
        a2 = 24'($urandom);
        l1 = $urandom_range(0, 2);
        l2 = $urandom_range(0, 2);
        rdy_mode = 1;
        q.delete();
        send_req(a1, 8'(l1));
        req_addr  = a2;
        req_len   = 8'(l2);
        req_valid = 1'b1;
        while (busy && t < 5000) begin
            if (req_ready !== 1'b0) bad++;
            tick;
            t++;
        end
        tick;
        req_valid = 1'b0;
        n_total++;
        if (bad !== 0) $display("FAIL b2b_ready_busy got %0d cycles want 0", bad);
        else n_pass++;
        wait_done(5000);
        n_total++;
        if (last_gap < CS_IDLE) $display("FAIL b2b_csb_gap got %0d want >=%0d", last_gap, CS_IDLE);
        else n_pass++;
        n_total++;
        if (q.size() !== l1 + l2 + 2) $display("FAIL b2b_count got %0d want %0d", q.size(), l1 + l2 + 2);
        else n_pass++;
        for (int i = 0; i < l1 + l2 + 2; i++) begin
            logic [31:0] e;
            e = (i <= l1) ? exp_word(a1, i) : exp_word(a2, i - l1 - 1);
            n_total++;
            if ({qget(i).d, qget(i).l} !== {e, (i == l1) || (i == l1 + l2 + 1)})
                $display("FAIL b2b_word%0d got %h/%b want %h", i, qget(i).d, qget(i).l, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort;
        int t = 0;
        rdy_mode = 0;
        q.delete();
        send_req(24'h0, 8'd3);
        while (fbit < 12 && t < 1000) begin tick; t++; end
        ap_rst = 1'b0;
        #1;
        n_total++;
        if ({csb, spiclk, busy} !== 3'b100) $display("FAIL abort_pins got %b want 100", {csb, spiclk, busy});
        else n_pass++;
        repeat (3) tick;
        ap_rst = 1'b1;
        repeat (2) tick;
        n_total++;
        if (q.size() !== 0) $display("FAIL abort_no_rsp got %0d want 0", q.size());
        else n_pass++;
        send_req(24'h000004, 8'd0);
        wait_done(2000);
        n_total++;
        if ({q.size(), qget(0).d, qget(0).l} !== {32'd1, 32'h88776655, 1'b1})
            $display("FAIL abort_next got n=%0d %h/%b want 1 88776655/1", q.size(), qget(0).d, qget(0).l);
        else n_pass++;
    endtask

    task automatic test_wrap;
        int errs = 0, nlast = 0;
        rdy_mode = 1;
        q.delete();
        send_req(24'hFFFFFC, 8'd255);
        wait_done(60000);
        n_total++;
        if (q.size() !== 256) $display("FAIL wrap_count got %0d want 256", q.size());
        else n_pass++;
        n_total++;
        if (qget(1).d !== 32'h44332211) $display("FAIL wrap_w1 got %h want 44332211", qget(1).d);
        else n_pass++;
        for (int i = 0; i < 256; i++) begin
            if (qget(i).d !== exp_word(24'hFFFFFC, i)) errs++;
            if (qget(i).l === 1'b1) nlast++;
        end
        n_total++;
        if (errs !== 0) $display("FAIL wrap_words got %0d bad words want 0", errs);
        else n_pass++;
        n_total++;
        if (nlast !== 1 || qget(255).l !== 1'b1) $display("FAIL wrap_last got %0d lasts w255=%b want 1/1", nlast, qget(255).l);
        else n_pass++;
    endtask

    task automatic test_random;
        for (int r = 0; r < 5; r++) begin
            logic [23:0] a;
            int l;
            a = 24'($urandom);
            l = $urandom_range(0, 6);
            rdy_mode = 1;
            q.delete();
            send_req(a, 8'(l));
            wait_done(8000);
            n_total++;
            if (q.size() !== l + 1) $display("FAIL rand%0d_count got %0d want %0d", r, q.size(), l + 1);
            else n_pass++;
            for (int i = 0; i <= l; i++) begin
                n_total++;
                if ({qget(i).d, qget(i).l} !== {exp_word(a, i), i == l})
                    $display("FAIL rand%0d_word%0d got %h/%b want %h/%b", r, i, qget(i).d, qget(i).l, exp_word(a, i), i == l);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_cmd_addr;
        test_backpressure;
        test_back_to_back;
        test_reset_abort;
        test_wrap;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
